// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF transmitter: preamble patterns, subframe slot map
// and block length.
package spdif_pkg;

    localparam int DATA_W           = 24;
    localparam int FRAMES_PER_BLOCK = 192;

    // Patterns are sent MSB first and assume the line sat at 0 before the preamble.
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [4:0] SLOT_AUD0 = 5'd4;
    localparam logic [4:0] SLOT_V    = 5'd28;
    localparam logic [4:0] SLOT_U    = 5'd29;
    localparam logic [4:0] SLOT_C    = 5'd30;
    localparam logic [4:0] SLOT_P    = 5'd31;

    typedef enum logic {
        SUB_L = 1'b0,
        SUB_R = 1'b1
    } sub_e;

    function automatic logic [7:0] preamble(input sub_e sub, input logic first_frame);
        if (sub == SUB_R) return PRE_W;
        return first_frame ? PRE_B : PRE_M;
    endfunction

endpackage

// File: rtl/spdif_bmc.sv
// Biphase-mark line coder: owns the line level, emits raw preamble UIs
// relative to the level the preamble started from, and BMC-codes data cells.
module spdif_bmc
    import spdif_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tick_i,
    input  logic ui_phase_i,
    input  logic is_preamble_i,
    input  logic pre_bit_i,
    input  logic data_bit_i,
    output logic spdif_o
);

    logic level_q, level_d;
    logic base_q, base_d;
    logic in_pre_q, in_pre_d;

    always_comb begin
        level_d  = level_q;
        base_d   = base_q;
        in_pre_d = in_pre_q;
        if (tick_i) begin
            in_pre_d = is_preamble_i;
            if (is_preamble_i) begin
                // Capture the reference level on the first preamble UI only.
                if (!in_pre_q) base_d = level_q;
                level_d = pre_bit_i ^ base_d;
            end else if (!ui_phase_i) begin
                level_d = ~level_q;
            end else begin
                level_d = level_q ^ data_bit_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            level_q  <= 1'b0;
            base_q   <= 1'b0;
            in_pre_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            base_q   <= base_d;
            in_pre_q <= in_pre_d;
        end
    end

    assign spdif_o = level_q;

endmodule

// File: rtl/spdif_encoder.sv
// IEC 60958 consumer transmitter: UI divider, subframe/frame counters, one-deep
// sample holding register with frame-start bypass, and V/U/C/P generation.
module spdif_encoder
    import spdif_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [31:0] CS_BITS = 32'h0200_0004
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              ena,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              spdif_out,
    output logic              block_start,
    output logic              underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);

    logic                     run;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [5:0]               ui_q, ui_d;
    sub_e                     sub_q, sub_d;
    logic [7:0]               frame_q, frame_d;
    logic                     hold_full_q;
    logic signed [DATA_W-1:0] hold_l_q, hold_r_q;
    logic signed [DATA_W-1:0] shift_l_q, shift_r_q;
    logic                     udr_q;
    logic                     block_start_q, underrun_q;
    logic                     tick, load, accept, starve;
    logic [4:0]               slot;
    logic [7:0]               pre_pat;
    logic signed [DATA_W-1:0] cur;
    logic                     chan_c, data_bit;

    assign run          = resetb && ena;
    assign tick         = (div_q == DIV_LAST);
    assign load         = tick && (ui_q == 6'd0) && (sub_q == SUB_L);
    assign accept       = sample_valid && !hold_full_q;
    assign starve       = !hold_full_q && !sample_valid;
    assign sample_ready = !hold_full_q;

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        ui_d    = ui_q;
        sub_d   = sub_q;
        frame_d = frame_q;
        if (tick) begin
            ui_d = ui_q + 6'd1;
            if (ui_q == 6'd63) begin
                sub_d = sub_e'(~sub_q);
                if (sub_q == SUB_R) frame_d = (frame_q == FRAME_LAST) ? 8'd0 : frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            div_q         <= '0;
            ui_q          <= 6'd0;
            sub_q         <= SUB_L;
            frame_q       <= 8'd0;
            hold_full_q   <= 1'b0;
            udr_q         <= 1'b0;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            ui_q          <= ui_d;
            sub_q         <= sub_d;
            frame_q       <= frame_d;
            block_start_q <= load && (frame_q == 8'd0);
            underrun_q    <= load && starve;
            // A load always leaves the hold empty; a frame-start bypass never fills it.
            if (load) begin
                hold_full_q <= 1'b0;
                udr_q       <= starve;
            end else if (accept) begin
                hold_full_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run && load) begin
            if (hold_full_q) begin
                shift_l_q <= hold_l_q;
                shift_r_q <= hold_r_q;
            end else if (sample_valid) begin
                shift_l_q <= sample_l;
                shift_r_q <= sample_r;
            end else begin
                shift_l_q <= '0;
                shift_r_q <= '0;
            end
        end
        if (run && accept && !load) begin
            hold_l_q <= sample_l;
            hold_r_q <= sample_r;
        end
    end

    assign slot    = ui_q[5:1];
    assign pre_pat = preamble(sub_q, frame_q == 8'd0);
    assign cur     = (sub_q == SUB_R) ? shift_r_q : shift_l_q;
    assign chan_c  = (frame_q < 8'd32) ? CS_BITS[frame_q[4:0]] : 1'b0;

    always_comb begin
        data_bit = 1'b0;
        if (slot >= SLOT_AUD0 && slot < SLOT_V) data_bit = cur[slot - SLOT_AUD0];
        else if (slot == SLOT_V)                data_bit = udr_q;
        else if (slot == SLOT_U)                data_bit = 1'b0;
        else if (slot == SLOT_C)                data_bit = chan_c;
        else if (slot == SLOT_P)                data_bit = (^cur) ^ udr_q ^ chan_c;
    end

    spdif_bmc u_bmc (
        .clk_i         (clk),
        .rst_n_i       (run),
        .tick_i        (tick),
        .ui_phase_i    (ui_q[0]),
        .is_preamble_i (slot < SLOT_AUD0),
        .pre_bit_i     (pre_pat[~ui_q[2:0]]),
        .data_bit_i    (data_bit),
        .spdif_o       (spdif_out)
    );

    assign block_start = block_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spdif_encoder.sv
// Scoreboard bench for spdif_encoder: random sample traffic, frame-level reference
// model, and a line decoder that checks preambles, BMC, audio and V/U/C/P.
`timescale 1ns/1ps
module tb_spdif_encoder;

    localparam int CD = 2;
    localparam int FR = CD * 128;
    localparam logic [31:0] CS = 32'h0200_0004;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        ena = 1'b1;
    logic [23:0] sample_l = 24'd0;
    logic [23:0] sample_r = 24'd0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, spdif_out, block_start, underrun;

    spdif_encoder #(.CLK_DIV(CD), .CS_BITS(CS)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .ena          (ena),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .spdif_out    (spdif_out),
        .block_start  (block_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
        logic        c;
        logic        first;
    } frame_t;

    pair_t  acc_q[$];
    frame_t exp_q[$];
    int     k = 0;
    int     checks = 0;
    int     errors = 0;
    int     frames_checked = 0;
    logic   last_out = 1'b0;
    logic   ui_buf[64];
    logic   mon_lvl = 1'b0;
    logic   mon_base = 1'b0;
    logic [31:0] cs_word = 32'd0;
    bit     acc_last = 1'b0;
    bit     bypass_last = 1'b0;

    function automatic void chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endfunction

    // Reference model: one pair per frame, taken from pairs accepted up to and
    // including that frame's start edge; otherwise an underrun frame.
    always @(posedge clk) begin : model
        bit     run;
        bit     exp_bs, exp_ur;
        int     u, n;
        frame_t f;
        pair_t  p;
        run    = resetb && ena;
        exp_bs = 1'b0;
        exp_ur = 1'b0;
        if (!run) begin
            k = 0;
            acc_q.delete();
            exp_q.delete();
        end else begin
            k++;
            if (k % CD == 0) begin
                u = k / CD - 1;
                if (u % 128 == 0) begin
                    n = (u / 128) % 192;
                    f.first = (n == 0);
                    f.c = (n < 32) ? CS[n] : 1'b0;
                    if (acc_q.size() > 0) begin
                        p = acc_q.pop_front();
                        f.l = p.l;
                        f.r = p.r;
                        f.v = 1'b0;
                    end else begin
                        f.l = 24'd0;
                        f.r = 24'd0;
                        f.v = 1'b1;
                        exp_ur = 1'b1;
                    end
                    exp_bs = f.first;
                    exp_q.push_back(f);
                end
            end
        end
        #1;
        if (!run) begin
            chk("reset_spdif", spdif_out, 0);
            chk("reset_ready", sample_ready, 1);
            chk("reset_block_start", block_start, 0);
            chk("reset_underrun", underrun, 0);
        end else begin
            chk("block_start", block_start, exp_bs);
            chk("underrun", underrun, exp_ur);
            if (k % CD != 0) chk("spdif_hold", spdif_out, last_out);
        end
        last_out = spdif_out;
    end

    // Line decoder: collects 64 UIs per subframe and compares against the model.
    always @(posedge clk) begin : monitor
        int          u, p, sb, n, bmc_bad;
        logic [7:0]  pat, want_pat;
        logic [31:0] bits;
        logic        prv;
        frame_t      e;
        #1;
        if (k == 0) begin
            mon_lvl = 1'b0;
        end else if (k % CD == 0) begin
            u  = k / CD - 1;
            p  = u % 64;
            sb = (u / 64) % 2;
            n  = (u / 128) % 192;
            if (p == 0) mon_base = mon_lvl;
            ui_buf[p] = spdif_out;
            mon_lvl   = spdif_out;
            if (p == 63) begin
                for (int i = 0; i < 8; i++) pat[7-i] = ui_buf[i] ^ mon_base;
                bmc_bad = 0;
                bits    = 32'd0;
                prv     = ui_buf[7];
                for (int s = 4; s < 32; s++) begin
                    if (ui_buf[2*s] == prv) bmc_bad++;
                    bits[s] = ui_buf[2*s] ^ ui_buf[2*s+1];
                    prv = ui_buf[2*s+1];
                end
                if (exp_q.size() == 0) begin
                    chk("exp_available", 0, 1);
                end else begin
                    e = exp_q[0];
                    want_pat = (sb == 1) ? 8'hE4 : (e.first ? 8'hE8 : 8'hE2);
                    chk((sb == 1) ? "preamble_R" : "preamble_L", pat, want_pat);
                    chk("bmc_cell_edge", bmc_bad, 0);
                    chk("parity", ^bits[31:4], 0);
                    chk((sb == 1) ? "audio_R" : "audio_L", bits[27:4], (sb == 1) ? e.r : e.l);
                    chk("V", bits[28], e.v);
                    chk("U", bits[29], 0);
                    chk("C", bits[30], e.c);
                    if (sb == 0 && n < 32) begin
                        cs_word[n] = bits[30];
                        if (n == 31) chk("cs_word", cs_word, 32'h0200_0004);
                    end
                    if (sb == 1) begin
                        void'(exp_q.pop_front());
                        frames_checked++;
                    end
                end
            end
        end
    end

    // Drives the inputs for the upcoming edge (k+1). Window f feeds frame f.
    task automatic drive_cycle();
        int    e, f;
        pair_t pp;
        e = k + 1;
        f = (e <= CD) ? 0 : (e - CD - 1) / FR + 1;
        if (bypass_last) chk("bypass_ready_after", sample_ready, 1);
        bypass_last = 1'b0;
        if (f % 16 == 5) begin
            sample_valid = 1'b0;
        end else if (f % 16 == 9) begin
            sample_valid = (e == CD * (128 * f + 1));
            if (sample_valid) begin
                sample_l = 24'($urandom);
                sample_r = 24'($urandom);
                chk("bypass_ready", sample_ready, 1);
                bypass_last = 1'b1;
            end
        end else if (sample_valid && !acc_last) begin
            // Stalled offer: data may change freely while not ready.
            sample_l = 24'($urandom);
            sample_r = 24'($urandom);
        end else begin
            sample_valid = ($urandom_range(0, 3) == 0);
            if (f < 3) begin
                sample_l = 24'h000001;
                sample_r = 24'h800000;
            end else begin
                sample_l = 24'($urandom);
                sample_r = 24'($urandom);
            end
        end
        acc_last = sample_valid && sample_ready;
        if (acc_last) begin
            pp.l = sample_l;
            pp.r = sample_r;
            acc_q.push_back(pp);
        end
    endtask

    task automatic quiesce();
        sample_valid = 1'b0;
        acc_last     = 1'b0;
        bypass_last  = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL timeout k=%0d frames=%0d", k, frames_checked);
        $fatal(1, "timeout");
    end

    initial begin
        resetb = 1'b0;
        ena    = 1'b1;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        while (k < 195 * FR) begin
            @(negedge clk);
            if (k < 195 * FR) drive_cycle();
        end

        // Reset pulse in the middle of an R subframe.
        while (k % FR != CD * 100) begin
            drive_cycle();
            @(negedge clk);
        end
        quiesce();
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        while (k < 3 * FR + 40) begin
            drive_cycle();
            @(negedge clk);
        end

        // Enable dropped mid L subframe, then restarted.
        quiesce();
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        while (k < 3 * FR) begin
            drive_cycle();
            @(negedge clk);
        end
        quiesce();
        @(negedge clk);

        chk("frames_checked", frames_checked, 201);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
